// File: rtl/stream_flush_sequencer.sv
// Flushable stream feeder: Depth-entry FIFO, flush sequencing with 4-phase req/ack, drop counter.
// One cycle from push to valid_o; ready_o drops when full, and outside IDLE both sides stall.

module stream_flush_fifo #(
  parameter type         T     = logic,
  parameter int unsigned Depth = 4,
  parameter int unsigned CntW  = $clog2(Depth + 1)
) (
  input  logic            clk_i,
  input  logic            rst_i,
  input  logic            push,
  input  T                push_dat,
  input  logic            pop,
  input  logic            clear,
  output logic            full,
  output logic            empty,
  output logic [CntW-1:0] count,
  output T                head_dat
);

  localparam int unsigned AW = (Depth > 1) ? $clog2(Depth) : 1;

  T                mem_q [Depth];
  logic [AW-1:0]   wr_ptr_q;
  logic [AW-1:0]   rd_ptr_q;
  logic [CntW-1:0] count_q;

  // Pointers wrap explicitly so Depth need not be a power of two.
  function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
    return (p == AW'(Depth - 1)) ? '0 : p + AW'(1);
  endfunction

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else if (clear) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (push && !clear) mem_q[wr_ptr_q] <= push_dat;
  end

  assign full     = (count_q == CntW'(Depth));
  assign empty    = (count_q == '0);
  assign count    = count_q;
  assign head_dat = empty ? T'('0) : mem_q[rd_ptr_q];

endmodule

module stream_flush_sequencer #(
  parameter type         T           = logic,
  parameter int unsigned Depth       = 4,
  parameter int unsigned FlushCycles = 2,
  parameter int unsigned CntWidth    = 16
) (
  input  logic                clk_i,
  input  logic                rst_i,
  input  logic                flush_req_i,
  output logic                flush_ack_o,
  output logic                busy_o,
  input  logic                valid_i,
  output logic                ready_o,
  input  T                    data_i,
  output logic                valid_o,
  output logic                flush_o,
  input  logic                ready_i,
  output T                    data_o,
  input  logic                clr_cnt_i,
  output logic [CntWidth-1:0] drop_cnt_o
);

  localparam int unsigned OW = $clog2(Depth + 1);
  localparam int unsigned FW = $clog2(FlushCycles + 1);
  localparam int unsigned SW = ((CntWidth > OW) ? CntWidth : OW) + 1;
  localparam logic [CntWidth-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FLUSH,
    ST_ACK
  } state_e;

  state_e              state_q, state_d;
  logic [FW-1:0]       fcnt_q;
  logic [CntWidth-1:0] drop_q, drop_d;
  logic [SW-1:0]       drop_sum;

  logic          fifo_push, fifo_pop, fifo_full, fifo_empty, first_flush;
  logic [OW-1:0] fifo_count;

  assign fifo_push   = valid_i && ready_o;
  assign fifo_pop    = valid_o && ready_i;
  assign first_flush = (state_q == ST_FLUSH) && (fcnt_q == '0);

  stream_flush_fifo #(
    .T     (T),
    .Depth (Depth),
    .CntW  (OW)
  ) u_fifo (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .push     (fifo_push),
    .push_dat (data_i),
    .pop      (fifo_pop),
    .clear    (first_flush),
    .full     (fifo_full),
    .empty    (fifo_empty),
    .count    (fifo_count),
    .head_dat (data_o)
  );

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Handshake outputs depend only on state and FIFO level, never on flush_req_i.
  always_comb begin
    state_d     = state_q;
    ready_o     = 1'b0;
    valid_o     = 1'b0;
    flush_o     = 1'b0;
    flush_ack_o = 1'b0;
    busy_o      = 1'b1;
    case (state_q)
      ST_IDLE: begin
        busy_o  = 1'b0;
        ready_o = !fifo_full;
        valid_o = !fifo_empty;
        if (flush_req_i) state_d = ST_FLUSH;
      end
      ST_FLUSH: begin
        flush_o = 1'b1;
        if (fcnt_q == FW'(FlushCycles - 1)) state_d = ST_ACK;
      end
      ST_ACK: begin
        flush_ack_o = 1'b1;
        if (!flush_req_i) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)                                               fcnt_q <= '0;
    else if ((state_q == ST_FLUSH) && (state_d == ST_FLUSH)) fcnt_q <= fcnt_q + FW'(1);
    else                                                     fcnt_q <= '0;
  end

  // Clear applies first, then the flushed occupancy is added with saturation.
  always_comb begin
    drop_sum = clr_cnt_i ? '0 : SW'(drop_q);
    if (first_flush) drop_sum = drop_sum + SW'(fifo_count);
    drop_d = (drop_sum > SW'(CNT_MAX)) ? CNT_MAX : drop_sum[CntWidth-1:0];
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) drop_q <= '0;
    else       drop_q <= drop_d;
  end

  assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_stream_flush_sequencer.sv
// Randomized and directed bench for stream_flush_sequencer against a queue-based reference model.
// A second instance with a 2-bit counter shares the stimulus to exercise saturation.

module tb_stream_flush_sequencer;

  localparam int DEPTH = 4;
  localparam int FC    = 2;

  logic       clk_i = 1'b0;
  logic       rst_i;
  logic       flush_req_i, valid_i, ready_i, clr_cnt_i;
  logic [7:0] data_i;

  logic        ack_a, busy_a, rdy_a, vld_a, fl_a;
  logic [7:0]  dat_a;
  logic [15:0] cnt_a_o;
  logic        ack_b, busy_b, rdy_b, vld_b, fl_b;
  logic [7:0]  dat_b;
  logic [1:0]  cnt_b_o;

  always #5 clk_i = ~clk_i;

  stream_flush_sequencer #(.T(logic [7:0]), .Depth(DEPTH), .FlushCycles(FC), .CntWidth(16)) u_dut (
    .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_ack_o(ack_a), .busy_o(busy_a),
    .valid_i(valid_i), .ready_o(rdy_a), .data_i(data_i), .valid_o(vld_a), .flush_o(fl_a),
    .ready_i(ready_i), .data_o(dat_a), .clr_cnt_i(clr_cnt_i), .drop_cnt_o(cnt_a_o)
  );

  stream_flush_sequencer #(.T(logic [7:0]), .Depth(DEPTH), .FlushCycles(FC), .CntWidth(2)) u_sat (
    .clk_i(clk_i), .rst_i(rst_i), .flush_req_i(flush_req_i), .flush_ack_o(ack_b), .busy_o(busy_b),
    .valid_i(valid_i), .ready_o(rdy_b), .data_i(data_i), .valid_o(vld_b), .flush_o(fl_b),
    .ready_i(ready_i), .data_o(dat_b), .clr_cnt_i(clr_cnt_i), .drop_cnt_o(cnt_b_o)
  );

  always @(negedge clk_i) begin
    if (!rst_i) assert (!(fl_a && vld_a) && !(fl_b && vld_b))
      else $error("flush_o and valid_o high together");
  end

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  // Reference model: beat queue, remaining flush cycles, ack phase flag, two counters.
  logic [7:0] q[$];
  int flush_left, cnt_a, cnt_b;
  bit in_ack, first;

  function automatic int sat(input int v, input int m);
    return (v > m) ? m : v;
  endfunction

  task automatic model_reset();
    q.delete();
    flush_left = 0;
    in_ack     = 0;
    first      = 0;
    cnt_a      = 0;
    cnt_b      = 0;
  endtask

  task automatic check_outputs();
    bit idle;
    logic [7:0] exp_dat;
    idle    = (flush_left == 0) && !in_ack;
    exp_dat = (q.size() > 0) ? q[0] : 8'h00;
    chk("ready_o",     32'(rdy_a),   32'(idle && (q.size() < DEPTH)));
    chk("valid_o",     32'(vld_a),   32'(idle && (q.size() > 0)));
    chk("data_o",      32'(dat_a),   32'(exp_dat));
    chk("flush_o",     32'(fl_a),    32'(flush_left > 0));
    chk("flush_ack_o", 32'(ack_a),   32'(in_ack));
    chk("busy_o",      32'(busy_a),  32'(!idle));
    chk("drop_cnt",    32'(cnt_a_o), 32'(cnt_a));
    chk("drop_cnt_sat", 32'(cnt_b_o), 32'(cnt_b));
    chk("sat_valid_o", 32'(vld_b),   32'(idle && (q.size() > 0)));
    chk("no_flush_and_valid", 32'(fl_a && vld_a), 32'(0));
  endtask

  task automatic model_step();
    bit idle, was_full;
    int base_a, base_b;
    idle     = (flush_left == 0) && !in_ack;
    was_full = (q.size() == DEPTH);
    base_a   = clr_cnt_i ? 0 : cnt_a;
    base_b   = clr_cnt_i ? 0 : cnt_b;
    if (idle) begin
      if (q.size() > 0 && ready_i) void'(q.pop_front());
      if (valid_i && !was_full) q.push_back(data_i);
      if (flush_req_i) begin
        flush_left = FC;
        first      = 1;
      end
    end else if (flush_left > 0) begin
      if (first) begin
        base_a += q.size();
        base_b += q.size();
        q.delete();
        first = 0;
      end
      flush_left--;
      if (flush_left == 0) in_ack = 1;
    end else if (!flush_req_i) begin
      in_ack = 0;
    end
    cnt_a = sat(base_a, 65535);
    cnt_b = sat(base_b, 3);
  endtask

  // Called one step after a rising edge: drive, check mid-cycle, advance model, cross the edge.
  task automatic cyc(input logic v, input logic [7:0] d, input logic r, input logic fr, input logic clr);
    valid_i     = v;
    data_i      = d;
    ready_i     = r;
    flush_req_i = fr;
    clr_cnt_i   = clr;
    @(negedge clk_i);
    check_outputs();
    model_step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic do_flush(input int n, input bit clr_first);
    for (int i = 0; i < n; i++) cyc(1'b1, 8'($urandom), 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, clr_first);
    for (int i = 0; i < FC; i++) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
  endtask

  initial begin
    bit req_r;
    rst_i       = 1'b1;
    valid_i     = 1'b0;
    ready_i     = 1'b0;
    flush_req_i = 1'b0;
    clr_cnt_i   = 1'b0;
    data_i      = 8'h00;
    model_reset();
    repeat (2) @(negedge clk_i);
    check_outputs();
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // In-order delivery with a draining consumer.
    cyc(1'b1, 8'hA1, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hB2, 1'b1, 1'b0, 1'b0);
    cyc(1'b1, 8'hC3, 1'b1, 1'b0, 1'b0);
    repeat (2) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Fill to full, then pop+push while full, then drain.
    for (int i = 0; i < 5; i++) cyc(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h55, 1'b1, 1'b0, 1'b0);
    repeat (5) cyc(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

    // Flush of 3 beats, request held well past ack.
    for (int i = 0; i < 3; i++) cyc(1'b1, 8'(8'h20 + i), 1'b0, 1'b0, 1'b0);
    repeat (FC + 7) cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("drop_after_first_flush", 32'(cnt_a_o), 32'd3);
    repeat (2) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

    // Request dropped early during FLUSH; flush on empty FIFO.
    cyc(1'b1, 8'h31, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    repeat (FC + 2) cyc(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    do_flush(0, 1'b0);

    // Saturation of the 2-bit counter, then clear coincident with a 2-beat flush.
    for (int k = 0; k < 3; k++) do_flush(3, 1'b0);
    chk("sat_saturated", 32'(cnt_b_o), 32'd3);
    do_flush(2, 1'b1);
    chk("sat_clr_then_add", 32'(cnt_b_o), 32'd2);
    chk("wide_clr_then_add", 32'(cnt_a_o), 32'd2);

    // Asynchronous reset in the middle of a flush.
    cyc(1'b1, 8'h41, 1'b0, 1'b0, 1'b0);
    cyc(1'b1, 8'h42, 1'b0, 1'b0, 1'b0);
    cyc(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
    chk("flush_o_before_rst", 32'(fl_a), 32'd1);
    flush_req_i = 1'b0;
    #2;
    rst_i = 1'b1;
    #1;
    chk("rst_flush_o", 32'(fl_a), 32'd0);
    chk("rst_valid_o", 32'(vld_a), 32'd0);
    chk("rst_ready_o", 32'(rdy_a), 32'd1);
    chk("rst_busy_o",  32'(busy_a), 32'd0);
    chk("rst_drop",    32'(cnt_a_o), 32'd0);
    model_reset();
    @(negedge clk_i);
    rst_i = 1'b0;
    @(posedge clk_i);
    #1;

    // Random traffic with 4-phase-ish requests and occasional clears.
    req_r = 1'b0;
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 9) == 0) req_r = !req_r;
      cyc(1'($urandom_range(0, 1)), 8'($urandom), 1'($urandom_range(0, 2) != 0), req_r,
          1'($urandom_range(0, 29) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
